// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared types and constants for the core-to-APB initiator bridge
package apb_master_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
   localparam logic [3:0] FULL_WORD_BE = 4'hF;
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/apb_master_timeout.sv
// apb_master_timeout: counts ACCESS cycles and flags when the wait budget is used up
module apb_master_timeout
   import apb_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic clear,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] count;
   logic active;
   // start arms the counter at 0 for the first ACCESS cycle; clear stops it when the transfer ends
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         active <= 1'b0;
         count  <= '0;
      end else if (start) begin
         active <= 1'b1;
         count  <= '0;
      end else if (active) begin
         count  <= count + 1'b1;
      end
   end
   assign expired = active && (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: core req/gnt/rvalid port to APB3 initiator, one transaction in flight
// Optional ACCESS-phase abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge
   import apb_master_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      data_req_i,
   input  logic [31:0]               data_addr_i,
   input  logic                      data_we_i,
   input  logic [3:0]                data_be_i,
   input  logic [31:0]               data_wdata_i,
   output logic                      data_gnt_o,
   output logic                      data_rvalid_o,
   output logic [31:0]               data_rdata_o,
   output logic                      data_err_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);
   if (APB_DATA_WIDTH != 32) begin : g_bad_data_width
      $fatal(1, "apb_master_bridge: APB_DATA_WIDTH must be 32");
   end
   if (APB_ADDR_WIDTH < 3 || APB_ADDR_WIDTH > 32) begin : g_bad_addr_width
      $fatal(1, "apb_master_bridge: APB_ADDR_WIDTH must be in 3..32");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $fatal(1, "apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   apb_state_e state_q, state_d;
   logic psel_d, penable_d, pwrite_d, rvalid_d, err_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_d;
   logic [31:0] rdata_d;
   logic expired;
   logic unused_addr_lsb;

   // byte offset is dropped: every APB access is word aligned
   assign unused_addr_lsb = ^data_addr_i[1:0];

`ifdef APB_MASTER_TIMEOUT_EN
   apb_master_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (state_q == SETUP),
      .clear   (state_q == ACCESS && (pready_i || expired)),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state, grant and next values of the registered APB/response outputs
   always_comb begin
      state_d    = state_q;
      data_gnt_o = 1'b0;
      psel_d     = psel_o;
      penable_d  = penable_o;
      pwrite_d   = pwrite_o;
      paddr_d    = paddr_o;
      pwdata_d   = pwdata_o;
      rvalid_d   = 1'b0;
      rdata_d    = '0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            data_gnt_o = data_req_i;
            if (data_req_i && data_we_i && data_be_i != FULL_WORD_BE) begin
               rvalid_d = 1'b1;
               err_d    = 1'b1;
            end else if (data_req_i) begin
               state_d  = SETUP;
               psel_d   = 1'b1;
               pwrite_d = data_we_i;
               paddr_d  = {data_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
               pwdata_d = data_we_i ? data_wdata_i : '0;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (pready_i || expired) begin
               state_d   = IDLE;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               pwrite_d  = 1'b0;
               paddr_d   = '0;
               pwdata_d  = '0;
               rvalid_d  = 1'b1;
               err_d     = pready_i ? pslverr_i : 1'b1;
               rdata_d   = (pready_i && !pwrite_o && !pslverr_i) ? prdata_i : '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // registered APB and response outputs; reset drops any in-flight transfer silently
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         psel_o        <= 1'b0;
         penable_o     <= 1'b0;
         pwrite_o      <= 1'b0;
         paddr_o       <= '0;
         pwdata_o      <= '0;
         data_rvalid_o <= 1'b0;
         data_rdata_o  <= '0;
         data_err_o    <= 1'b0;
      end else begin
         psel_o        <= psel_d;
         penable_o     <= penable_d;
         pwrite_o      <= pwrite_d;
         paddr_o       <= paddr_d;
         pwdata_o      <= pwdata_d;
         data_rvalid_o <= rvalid_d;
         data_rdata_o  <= rdata_d;
         data_err_o    <= err_d;
      end
   end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vector table plus corner-case sequences for apb_master_bridge
module tb_apb_master_bridge;
   logic clk = 1'b0;
   logic rst_n, req, we, pready, pslverr;
   logic [31:0] addr, wdata, prdata;
   logic [3:0] be;
   logic gnt, rvalid, err, psel, penable, pwrite;
   logic [31:0] rdata, paddr, pwdata;
   int total = 0;
   int passed = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      logic [31:0] exp_paddr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_psel;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   apb_master_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_req_i    (req),
      .data_addr_i   (addr),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_wdata_i  (wdata),
      .data_gnt_o    (gnt),
      .data_rvalid_o (rvalid),
      .data_rdata_o  (rdata),
      .data_err_o    (err),
      .psel_o        (psel),
      .penable_o     (penable),
      .pwrite_o      (pwrite),
      .paddr_o       (paddr),
      .pwdata_o      (pwdata),
      .prdata_i      (prdata),
      .pready_i      (pready),
      .pslverr_i     (pslverr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      else passed++;
   endtask

   // one granted request against a slave that inserts v.waits wait states
   task automatic run_txn(input vec_t v, input int idx);
      int acc = 0;
      int psel_cyc = 0;
      int rv_cyc = -1;
      int rv_cnt = 0;
      logic stable = 1'b1;
      logic [31:0] rd = '0;
      logic er = 1'b0;
      string tag = $sformatf("v%0d", idx);
      @(negedge clk);
      req = 1'b1; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
      #1 check({tag, "_gnt"}, 32'(gnt), 32'd1);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         req = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
         #1;
         if (psel) begin
            psel_cyc++;
            if (paddr !== v.exp_paddr || pwrite !== v.we || pwdata !== (v.we ? v.wdata : 32'd0)) stable = 1'b0;
         end
         if (psel && penable) begin
            if (acc == v.waits) begin
               pready = 1'b1; prdata = v.prdata; pslverr = v.slverr;
            end
            acc++;
         end
         if (rvalid) begin
            rv_cnt++;
            if (rv_cyc < 0) begin
               rv_cyc = cyc; rd = rdata; er = err;
            end
         end
         if (rv_cyc >= 0 && cyc > rv_cyc) break;
      end
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
      check({tag, "_latency"}, 32'(rv_cyc), 32'(v.exp_lat));
      check({tag, "_rdata"}, rd, v.exp_rdata);
      check({tag, "_err"}, 32'(er), 32'(v.exp_err));
      check({tag, "_rvalid_count"}, 32'(rv_cnt), 32'd1);
      check({tag, "_psel_cycles"}, 32'(psel_cyc), 32'(v.exp_psel));
      check({tag, "_apb_stable"}, 32'(stable), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      //               we    addr           be     wdata          waits prdata         slverr paddr          rdata          err  lat psel
      vecs[0] = '{1'b0, 32'h1A10_0004, 4'hF,  32'h0,         0, 32'hCAFE_0001, 1'b0, 32'h1A10_0004, 32'hCAFE_0001, 1'b0, 3, 2};
      vecs[1] = '{1'b1, 32'h1A10_1000, 4'hF,  32'h0000_00A5, 3, 32'h0,         1'b0, 32'h1A10_1000, 32'h0,         1'b0, 6, 5};
      vecs[2] = '{1'b1, 32'h1A10_2000, 4'h3,  32'h1234_5678, 0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 1, 0};
      vecs[3] = '{1'b0, 32'h1A10_0008, 4'hF,  32'h0,         0, 32'hDEAD_BEEF, 1'b1, 32'h1A10_0008, 32'h0,         1'b1, 3, 2};
      vecs[4] = '{1'b0, 32'h1A10_0013, 4'h0,  32'h0,         1, 32'h1234_5678, 1'b0, 32'h1A10_0010, 32'h1234_5678, 1'b0, 4, 3};
      vecs[5] = '{1'b1, 32'h0000_0FFC, 4'hF,  32'hFFFF_FFFF, 2, 32'hAAAA_AAAA, 1'b1, 32'h0000_0FFC, 32'h0,         1'b1, 5, 4};
      vecs[6] = '{1'b1, 32'h0000_0006, 4'hF,  32'h8000_0001, 0, 32'h0,         1'b0, 32'h0000_0004, 32'h0,         1'b0, 3, 2};

      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      pready = 1'b0; prdata = '0; pslverr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_psel", 32'(psel), 32'd0);
      check("rst_penable", 32'(penable), 32'd0);
      check("rst_pwrite", 32'(pwrite), 32'd0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err", 32'(err), 32'd0);

      for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

      // slave error read, next request held through the busy phase and granted in the rvalid cycle
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h1A10_0020; be = 4'hF;
      #1 check("b2b_gnt_first", 32'(gnt), 32'd1);
      @(negedge clk);
      addr = 32'h1A10_0030;
      #1 check("b2b_gnt_setup", 32'(gnt), 32'd0);
      check("b2b_setup_penable", 32'(penable), 32'd0);
      @(negedge clk);
      pready = 1'b1; pslverr = 1'b1; prdata = 32'h1111_2222;
      #1 check("b2b_gnt_access", 32'(gnt), 32'd0);
      check("b2b_paddr_held", paddr, 32'h1A10_0020);
      @(negedge clk);
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      #1 check("b2b_rvalid", 32'(rvalid), 32'd1);
      check("b2b_err", 32'(err), 32'd1);
      check("b2b_rdata", rdata, 32'd0);
      check("b2b_gnt_in_rvalid", 32'(gnt), 32'd1);
      @(negedge clk);
      req = 1'b0;
      #1 check("b2b2_psel", 32'(psel), 32'd1);
      check("b2b2_paddr", paddr, 32'h1A10_0030);
      check("b2b2_rvalid_low", 32'(rvalid), 32'd0);
      @(negedge clk);
      pready = 1'b1; prdata = 32'h55AA_0F0F;
      #1 check("b2b2_penable", 32'(penable), 32'd1);
      @(negedge clk);
      pready = 1'b0; prdata = '0;
      #1 check("b2b2_rvalid", 32'(rvalid), 32'd1);
      check("b2b2_rdata", rdata, 32'h55AA_0F0F);
      check("b2b2_err", 32'(err), 32'd0);

      // reset during ACCESS drops the transfer without a response
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h1A10_0040; be = 4'hF;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      #1 check("rstacc_in_access", 32'(penable), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      #1 check("rstacc_psel", 32'(psel), 32'd0);
      check("rstacc_penable", 32'(penable), 32'd0);
      check("rstacc_rvalid", 32'(rvalid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1 check("rstacc_no_late_rvalid", 32'(rvalid), 32'd0);
      run_txn(vecs[0], 10);

`ifdef APB_MASTER_TIMEOUT_EN
      begin
         int acc = 0;
         int rv_cyc = -1;
         int rv_cnt = 0;
         logic er = 1'b0;
         logic [31:0] rd = 32'hFFFF_FFFF;
         @(negedge clk);
         req = 1'b1; we = 1'b0; addr = 32'h1A10_0050; be = 4'hF;
         for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            req = 1'b0;
            pready = (cyc >= 10);
            prdata = 32'h7777_7777;
            #1;
            if (psel && penable) acc++;
            if (rvalid) begin
               rv_cnt++;
               if (rv_cyc < 0) begin
                  rv_cyc = cyc; er = err; rd = rdata;
               end
            end
         end
         pready = 1'b0; prdata = '0;
         check("to_access_cycles", 32'(acc), 32'd8);
         check("to_rvalid_cycle", 32'(rv_cyc), 32'd10);
         check("to_err", 32'(er), 32'd1);
         check("to_rdata", rd, 32'd0);
         check("to_rvalid_count", 32'(rv_cnt), 32'd1);
      end
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
